// File: rtl/booth_seq_multiplier.sv
// Sequential radix-4 Booth multiplier: 8x8 signed -> 16-bit signed, one Booth digit per cycle,
// with ready/valid handshakes on the operand and product sides.

module booth_r4_encoder (
  input  logic [2:0] triplet,
  input  logic [7:0] multiplicand,
  output logic [8:0] pp,
  output logic       sign
);
  logic [8:0] a9;
  assign a9 = {multiplicand[7], multiplicand};

  // Negative digits return the one's complement; the caller adds the +1 via sign.
  always_comb begin
    pp   = '0;
    sign = 1'b0;
    case (triplet)
      3'b001, 3'b010: pp = a9;
      3'b011:         pp = {multiplicand, 1'b0};
      3'b100: begin
        pp   = ~{multiplicand, 1'b0};
        sign = 1'b1;
      end
      3'b101, 3'b110: begin
        pp   = ~a9;
        sign = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

module booth_seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);
  localparam int ITER = WIDTH / 2;

  if (WIDTH != 8) begin : g_width_check
    $error("booth_seq_multiplier: only WIDTH=8 is supported by the encoder");
  end

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state_q, state_d;
  logic [7:0]  a_q, a_d, b_q, b_d;
  logic [15:0] acc_q, acc_d;
  logic [1:0]  cnt_q, cnt_d;

  logic [2:0]  triplet;
  logic [8:0]  pp;
  logic        pp_sign;
  logic [2:0]  shamt;
  logic [15:0] pp_ext, addend;

  // Triplet chosen by a mux on the iteration count so b_q stays intact.
  always_comb begin
    case (cnt_q)
      2'd0:    triplet = {b_q[1:0], 1'b0};
      2'd1:    triplet = b_q[3:1];
      2'd2:    triplet = b_q[5:3];
      default: triplet = b_q[7:5];
    endcase
  end

  booth_r4_encoder u_enc (
    .triplet      (triplet),
    .multiplicand (a_q),
    .pp           (pp),
    .sign         (pp_sign)
  );

  assign shamt  = {cnt_q, 1'b0};
  assign pp_ext = {{7{pp[8]}}, pp};
  assign addend = (pp_ext << shamt) + ({15'd0, pp_sign} << shamt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    product   = '0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        busy  = 1'b1;
        acc_d = acc_q + addend;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'(ITER - 1)) state_d = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        product   = acc_q;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Self-checking bench for booth_seq_multiplier: directed corners, backpressure, mid-op reset,
// random regression against plain signed multiplication, and back-to-back throughput.

module tb_booth_seq_multiplier;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] product;
  logic        busy;

  int tests = 0;
  int fails = 0;

  booth_seq_multiplier #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
    int p;
    p = int'($signed(x)) * int'($signed(y));
    return p[15:0];
  endfunction

  // Drives one operation from an IDLE negedge; stalls out_ready for 'stall' cycles while
  // throwing ignored in_valid pulses at the block, then completes the handshake.
  task automatic run_op(input logic [7:0] opa, input logic [7:0] opb, input int stall,
                        output logic [15:0] got, output int lat, output bit stable);
    int w;
    lat = -1;
    stable = 1'b1;
    got = 'x;
    w = 0;
    while (!in_ready && w < 20) begin @(negedge clk); w++; end
    if (!in_ready) return;
    a = opa; b = opb; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 20) begin @(negedge clk); w++; end
    if (!out_valid) return;
    lat = w;
    got = product;
    repeat (stall) begin
      a = 8'($urandom); b = 8'($urandom); in_valid = 1'($urandom);
      @(negedge clk);
      if (out_valid !== 1'b1 || product !== got || in_ready !== 1'b0) stable = 1'b0;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || product !== 16'h0000) begin
      fails++;
      $display("[TB] FAIL reset: in_ready=%b out_valid=%b busy=%b product=%h, want 1 0 0 0000",
               in_ready, out_valid, busy, product);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [15:0] got; int lat; bit st;
    run_op(8'd7, 8'd5, 0, got, lat, st);
    tests++;
    if (lat !== 4) begin
      fails++; $display("[TB] FAIL basic_latency: got %0d want 4", lat);
    end
    tests++;
    if (got !== 16'h0023) begin
      fails++; $display("[TB] FAIL basic_product: got %h want 0023", got);
    end
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++; $display("[TB] FAIL basic_return: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_corners();
    logic [7:0] ca[5] = '{8'h80, 8'h80, 8'hFF, 8'h5A, 8'h00};
    logic [7:0] cb[5] = '{8'h80, 8'h7F, 8'hFF, 8'h00, 8'hB3};
    logic [15:0] ce[5] = '{16'h4000, 16'hC080, 16'h0001, 16'h0000, 16'h0000};
    logic [15:0] got; int lat; bit st;
    for (int i = 0; i < 5; i++) begin
      run_op(ca[i], cb[i], 0, got, lat, st);
      tests++;
      if (got !== ce[i] || lat !== 4) begin
        fails++;
        $display("[TB] FAIL corner_%0d: a=%h b=%h product=%h lat=%0d want %h lat=4",
                 i, ca[i], cb[i], got, lat, ce[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] got; int lat; bit st;
    run_op(8'd3, 8'hFC, 10, got, lat, st);
    tests++;
    if (got !== 16'hFFF4 || lat !== 4) begin
      fails++; $display("[TB] FAIL bp_product: got %h lat=%0d want FFF4 lat=4", got, lat);
    end
    tests++;
    if (!st) begin
      fails++; $display("[TB] FAIL bp_stable: output changed or in_ready rose during stall, want held");
    end
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++; $display("[TB] FAIL bp_handshake: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
    run_op(8'd11, 8'hFA, 0, got, lat, st);
    tests++;
    if (got !== 16'hFFBE) begin
      fails++; $display("[TB] FAIL bp_next: got %h want FFBE", got);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] got; int lat; bit st;
    a = 8'd50; b = 8'hB3; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    tests++;
    if (out_valid !== 1'b0 || product !== 16'h0000 || in_ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL mid_reset: out_valid=%b product=%h in_ready=%b busy=%b want 0 0000 1 0",
               out_valid, product, in_ready, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op(8'hFD, 8'd9, 0, got, lat, st);
    tests++;
    if (got !== 16'hFFE5 || lat !== 4) begin
      fails++; $display("[TB] FAIL mid_reset_next: got %h lat=%0d want FFE5 lat=4", got, lat);
    end
  endtask

  task automatic test_random();
    logic [15:0] got, exp; int lat; bit st; int stall;
    logic [7:0] ra, rb;
    for (int i = 0; i < 10000; i++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      stall = ($urandom_range(7) == 0) ? int'($urandom_range(3, 1)) : 0;
      exp = ref_mul(ra, rb);
      run_op(ra, rb, stall, got, lat, st);
      tests++;
      if (got !== exp || lat !== 4 || !st) begin
        fails++;
        $display("[TB] FAIL random_%0d: a=%h b=%h product=%h lat=%0d stable=%0b want %h lat=4 stable=1",
                 i, ra, rb, got, lat, st, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] q[$];
    logic [15:0] exp;
    int done = 0;
    int last = -1;
    int cyc = 0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    while (done < 100 && cyc < 1000) begin
      if (out_valid) begin
        exp = (q.size() > 0) ? q.pop_front() : 16'hxxxx;
        tests++;
        if (product !== exp || (last >= 0 && cyc - last != 6)) begin
          fails++;
          $display("[TB] FAIL b2b_%0d: product=%h interval=%0d want %h interval=6",
                   done, product, cyc - last, exp);
        end
        last = cyc;
        done++;
        if (done == 100) in_valid = 1'b0;
      end
      if (in_ready && in_valid) begin
        a = 8'($urandom); b = 8'($urandom);
        q.push_back(ref_mul(a, b));
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    tests++;
    if (done != 100) begin
      fails++; $display("[TB] FAIL b2b_timeout: completed %0d want 100", done);
    end
    out_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_corners();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
